trace_capture_buffer: RTL and testbench

Hardware retirement trace buffer that records per-instruction pc, inst and alu_out from cpu_top into a circular store, and replays the records later over a valid/ready stream. It generalises the fixed "run 10 cycles and print" debug flow into a parametrised, armable capture unit. Capture supports a pc-match trigger, and either a one-shot mode or a wrap-until-stop mode. It sits beside cpu_top and is driven by the core's retire signals.

---
 rtl/trace_capture_buffer.sv | 154 +++++++++++++++
 tb/tb_trace_capture_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// Retirement trace buffer: captures {pc, inst, alu_out} per retired instruction into a
// circular store (one-shot or wrap-until-stop, optional pc trigger) and replays it oldest first.
module trace_capture_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trace_valid,
    input  logic [XLEN-1:0] trace_pc,
    input  logic [31:0]     trace_inst,
    input  logic [XLEN-1:0] trace_alu_out,
    input  logic            arm,
    input  logic            stop,
    input  logic            cfg_mode,
    input  logic [CW-1:0]   cfg_count,
    input  logic            cfg_trig_en,
    input  logic [XLEN-1:0] cfg_trig_pc,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   entries,
    output logic            overflow,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_alu_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   entries_q, entries_d, eff_count_q, eff_count_d;
    logic            overflow_q, overflow_d;
    logic            mode_q, mode_d;
    logic [XLEN-1:0] trig_pc_q, trig_pc_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            wr_en;

    logic [XLEN-1:0] mem_pc  [DEPTH];
    logic [31:0]     mem_inst[DEPTH];
    logic [XLEN-1:0] mem_alu [DEPTH];

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        entries_d   = entries_q;
        eff_count_d = eff_count_q;
        overflow_d  = overflow_q;
        mode_d      = mode_q;
        trig_pc_d   = trig_pc_q;
        wr_en       = 1'b0;

        if (arm) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            entries_d   = '0;
            overflow_d  = 1'b0;
            mode_d      = cfg_mode;
            trig_pc_d   = cfg_trig_pc;
            eff_count_d = (cfg_count == '0 || cfg_count > FULL) ? FULL : cfg_count;
            state_d     = cfg_trig_en ? S_ARMED : S_CAPTURE;
        end else begin
            unique case (state_q)
                S_ARMED: begin
                    if (trace_valid && trace_pc == trig_pc_q) begin
                        wr_en     = 1'b1;
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                        entries_d = CW'(1);
                        state_d   = (!mode_q && eff_count_q == CW'(1)) ? S_DONE : S_CAPTURE;
                    end
                    if (stop) state_d = S_DONE;
                end
                S_CAPTURE: begin
                    if (trace_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        // A full circular store drops its oldest record to make room.
                        if (mode_q && entries_q == FULL) begin
                            rd_ptr_d   = rd_ptr_q + 1'b1;
                            overflow_d = 1'b1;
                        end else begin
                            entries_d = entries_q + 1'b1;
                        end
                        if (!mode_q && entries_d == eff_count_q) state_d = S_DONE;
                    end
                    if (stop) state_d = S_DONE;
                end
                S_DONE: begin
                    if (entries_q != '0 && out_ready) begin
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                        entries_d = entries_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            entries_q   <= '0;
            eff_count_q <= '0;
            overflow_q  <= 1'b0;
            mode_q      <= 1'b0;
            trig_pc_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            entries_q   <= entries_d;
            eff_count_q <= eff_count_d;
            overflow_q  <= overflow_d;
            mode_q      <= mode_d;
            trig_pc_q   <= trig_pc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // NOTE: the storage array is not reset; entries/out_valid gate every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr_q]   <= trace_pc;
            mem_inst[wr_ptr_q] <= trace_inst;
            mem_alu[wr_ptr_q]  <= trace_alu_out;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign entries     = entries_q;
    assign overflow    = overflow_q;
    assign out_valid   = done_q && (entries_q != '0);
    assign out_pc      = out_valid ? mem_pc[rd_ptr_q]   : '0;
    assign out_inst    = out_valid ? mem_inst[rd_ptr_q] : '0;
    assign out_alu_out = out_valid ? mem_alu[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Scoreboard bench for trace_capture_buffer: a behavioural model queues expected records
// as retires are driven; records are popped and compared on each output handshake.
module tb_trace_capture_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            trace_valid = 1'b0;
    logic [XLEN-1:0] trace_pc = '0;
    logic [31:0]     trace_inst = '0;
    logic [XLEN-1:0] trace_alu_out = '0;
    logic            arm = 1'b0, stop = 1'b0;
    logic            cfg_mode = 1'b0, cfg_trig_en = 1'b0;
    logic [CW-1:0]   cfg_count = '0;
    logic [XLEN-1:0] cfg_trig_pc = '0;
    logic            busy, done, overflow, out_valid;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   entries;
    logic [XLEN-1:0] out_pc, out_alu_out;
    logic [31:0]     out_inst;

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t exp_q[$];
    int   m_state = 0;  // 0 idle, 1 armed, 2 capture, 3 done
    bit   m_mode, m_ovf;
    int   m_eff;
    logic [31:0] m_trig;

    trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_inst(trace_inst),
        .trace_alu_out(trace_alu_out),
        .arm(arm), .stop(stop),
        .cfg_mode(cfg_mode), .cfg_count(cfg_count), .cfg_trig_en(cfg_trig_en),
        .cfg_trig_pc(cfg_trig_pc),
        .busy(busy), .done(done), .entries(entries), .overflow(overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_alu_out(out_alu_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input bit mode, input int count, input bit trig_en,
                          input logic [31:0] trig_pc, input bit with_stop);
        cfg_mode    = mode;
        cfg_count   = CW'(count);
        cfg_trig_en = trig_en;
        cfg_trig_pc = trig_pc;
        arm  = 1'b1;
        stop = with_stop;
        tick();
        arm  = 1'b0;
        stop = 1'b0;
        exp_q.delete();
        m_mode  = mode;
        m_eff   = (count == 0 || count > DEPTH) ? DEPTH : count;
        m_trig  = trig_pc;
        m_ovf   = 1'b0;
        m_state = trig_en ? 1 : 2;
    endtask

    task automatic retire(input logic [31:0] pc, input bit with_stop);
        rec_t r, dropped;
        r.pc   = pc;
        r.inst = {pc[15:0], 16'hC0DE};
        r.alu  = pc * 3 + 1;
        trace_valid   = 1'b1;
        trace_pc      = r.pc;
        trace_inst    = r.inst;
        trace_alu_out = r.alu;
        stop          = with_stop;
        if (m_state == 1 && pc == m_trig) begin
            exp_q.push_back(r);
            m_state = (!m_mode && m_eff == 1) ? 3 : 2;
        end else if (m_state == 2) begin
            exp_q.push_back(r);
            if (exp_q.size() > DEPTH) begin
                dropped = exp_q.pop_front();
                m_ovf = 1'b1;
            end
            if (!m_mode && exp_q.size() == m_eff) m_state = 3;
        end
        if (with_stop && (m_state == 1 || m_state == 2)) m_state = 3;
        tick();
        trace_valid = 1'b0;
        stop        = 1'b0;
    endtask

    task automatic cmp_head(input string tag);
        rec_t r;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 64'(out_valid), 64'd0);
        end else begin
            r = exp_q.pop_front();
            check({tag, "_pc"}, 64'(out_pc), 64'(r.pc));
            check({tag, "_inst"}, 64'(out_inst), 64'(r.inst));
            check({tag, "_alu"}, 64'(out_alu_out), 64'(r.alu));
        end
    endtask

    task automatic drain_all(input string tag);
        int budget = 200;
        out_ready = 1'b1;
        while ((out_valid || exp_q.size() != 0) && budget > 0) begin
            if (out_valid) cmp_head(tag);
            tick();
            budget--;
        end
        out_ready = 1'b0;
        check({tag, "_drain_timeout"}, 64'(budget > 0), 64'd1);
        check({tag, "_empty_entries"}, 64'(entries), 64'd0);
        check({tag, "_empty_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] prev_pc;
        logic [CW-1:0] prev_ent;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (10) tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_entries", 64'(entries), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);

        // One-shot capture of 10 out of 12 retires
        do_arm(1'b0, 10, 1'b0, 32'h0, 1'b0);
        check("m0_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 12; i++) begin
            retire(32'(i * 4), 1'b0);
            if (i == 8) check("m0_not_done_9", 64'(done), 64'd0);
            if (i == 9) check("m0_done_10", 64'(done), 64'd1);
        end
        check("m0_entries", 64'(entries), 64'd10);
        check("m0_overflow", 64'(overflow), 64'd0);
        check("m0_first_pc", 64'(out_pc), 64'd0);
        drain_all("m0");

        // pc-match trigger
        do_arm(1'b0, 3, 1'b1, 32'h20, 1'b0);
        for (int pc = 32'h10; pc <= 32'h30; pc += 4) begin
            retire(32'(pc), 1'b0);
            if (pc < 32'h20) begin
                check("trg_wait_busy", 64'(busy), 64'd1);
                check("trg_wait_entries", 64'(entries), 64'd0);
            end
        end
        check("trg_done", 64'(done), 64'd1);
        check("trg_entries", 64'(entries), 64'd3);
        check("trg_first_pc", 64'(out_pc), 64'h20);
        drain_all("trg");

        // Circular wrap, stop with the 21st retire
        do_arm(1'b1, 0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i <= 20; i++) retire(32'(i * 4), i == 20);
        check("circ_done", 64'(done), 64'd1);
        check("circ_entries", 64'(entries), 64'd16);
        check("circ_overflow", 64'(overflow), 64'(m_ovf));
        check("circ_oldest_pc", 64'(out_pc), 64'h14);
        drain_all("circ");

        // Backpressure during drain
        do_arm(1'b0, 4, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) retire(32'h100 + 32'(i * 4), 1'b0);
        for (int k = 0; k < 4; k++) begin
            out_ready = pat[k];
            prev_pc   = out_pc;
            prev_ent  = entries;
            if (pat[k] && out_valid) cmp_head("bp");
            tick();
            check("bp_entries", 64'(entries), 64'(prev_ent - CW'(pat[k])));
            if (!pat[k]) check("bp_hold_pc", 64'(out_pc), 64'(prev_pc));
        end
        out_ready = 1'b0;
        check("bp_left", 64'(entries), 64'd2);
        drain_all("bp");

        // arm + stop together in CAPTURE restarts the capture
        do_arm(1'b1, 0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 18; i++) retire(32'h400 + 32'(i * 4), 1'b0);
        check("sim_pre_overflow", 64'(overflow), 64'(m_ovf));
        do_arm(1'b1, 0, 1'b0, 32'h0, 1'b1);
        check("sim_busy", 64'(busy), 64'd1);
        check("sim_done", 64'(done), 64'd0);
        check("sim_entries", 64'(entries), 64'd0);
        check("sim_overflow", 64'(overflow), 64'd0);

        // stop while ARMED
        do_arm(1'b0, 4, 1'b1, 32'hFFF0, 1'b0);
        retire(32'h500, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        m_state = 3;
        check("armstop_done", 64'(done), 64'd1);
        check("armstop_busy", 64'(busy), 64'd0);
        check("armstop_entries", 64'(entries), 64'd0);
        check("armstop_valid", 64'(out_valid), 64'd0);

        // Reset in mid-drain, then count=0 clamps to DEPTH
        do_arm(1'b0, 8, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) retire(32'h200 + 32'(i * 4), 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmp_head("rst_drain");
            tick();
        end
        out_ready = 1'b0;
        check("rstmid_entries_before", 64'(entries), 64'd5);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        check("rstmid_entries", 64'(entries), 64'd0);
        check("rstmid_overflow", 64'(overflow), 64'd0);
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_pc", 64'(out_pc), 64'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        m_state = 0;
        tick();
        check("rstmid_idle_valid", 64'(out_valid), 64'd0);

        do_arm(1'b0, 0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            retire(32'h300 + 32'(i * 4), 1'b0);
            if (i == 14) check("clamp_not_done_15", 64'(done), 64'd0);
            if (i == 15) check("clamp_done_16", 64'(done), 64'd1);
        end
        check("clamp_entries", 64'(entries), 64'd16);
        check("clamp_first_pc", 64'(out_pc), 64'h300);
        drain_all("clamp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
